avr2wb_cyc_ctrl: RTL



---
 rtl/avr2wb_pkg.sv | 27 ++
 rtl/avr2wb_cyc_ctrl_if.sv | 26 ++
 rtl/avr2wb_tmo_cnt.sv | 27 ++
 rtl/avr2wb_cyc_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/avr2wb_pkg.sv
// Shared definitions for the AVR-to-Wishbone cycle controller.
// Holds the FSM encoding, the error read value and the byte-lane selector.
package avr2wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] C_ERR_RDATA = 8'hFF;

    // Picks the byte that the 8-bit AVR access addresses inside the 32-bit word.
    function automatic logic [7:0] lane_sel(input logic [31:0] i_word, input logic [1:0] i_lane);
        logic [7:0] v_byte;
        v_byte = i_word[7:0];
        case (i_lane)
            2'd0: v_byte = i_word[7:0];
            2'd1: v_byte = i_word[15:8];
            2'd2: v_byte = i_word[23:16];
            2'd3: v_byte = i_word[31:24];
            default: v_byte = i_word[7:0];
        endcase
        return v_byte;
    endfunction

endpackage

// File: rtl/avr2wb_cyc_ctrl_if.sv
// Classic single-transfer Wishbone bus between the bridge (master) and a slave.
// Handshake: stb is the master's valid; ack or err is the slave's ready/terminate,
// and the transfer completes on the first cycle where stb & (ack | err) is sampled.
interface avr2wb_cyc_ctrl_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/avr2wb_tmo_cnt.sv
// Saturating bus-timeout counter. Start loads 1 so the count equals the number of
// BUS cycles spent including the current one; expired flags the all-ones count.
module avr2wb_tmo_cnt #(
    parameter int P_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_en,
    output logic o_expired
);

    logic [P_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= P_WIDTH'(1);
        end else if (i_en && !(&r_cnt)) begin
            r_cnt <= r_cnt + P_WIDTH'(1);
        end
    end

    assign o_expired = &r_cnt;

endmodule

// File: rtl/avr2wb_cyc_ctrl.sv
// Turns one AVR data-memory access into one classic Wishbone read or write,
// stalling the core through cpuwait until ack, err or timeout terminates it.
module avr2wb_cyc_ctrl
    import avr2wb_pkg::*;
#(
    parameter int P_TMO_WIDTH = 8,
    parameter int P_TMO_EN    = 1
) (
    input  logic              cp2,
    input  logic              ireset,
    input  logic              sel,
    input  logic [7:0]        ramadr,
    input  logic              ramre,
    input  logic              ramwe,
    input  logic [7:0]        dbus_in,
    output logic [7:0]        dbus_out,
    output logic              cpuwait,
    input  logic [23:0]       wb_adr_hi,
    input  logic [3:0]        wb_be,
    input  logic              wb_rst,
    input  logic              err_clr,
    output logic              err_flag,
    avr2wb_cyc_ctrl_if.master wb,
    output state_t            o_dbg_state
);

    state_t      r_state;
    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic [7:0]  r_dbus_out;
    logic        r_err_flag;

    state_t      w_state_nxt;
    logic        w_req;
    logic        w_start;
    logic        w_done_ok;
    logic        w_done_err;
    logic        w_expired;

    assign w_req = sel & (ramre | ramwe);

    avr2wb_tmo_cnt #(.P_WIDTH(P_TMO_WIDTH)) u_tmo_cnt (
        .clk       (cp2),
        .rst       (ireset),
        .i_start   (w_start),
        .i_en      (r_state == ST_BUS),
        .o_expired (w_expired)
    );

    always_ff @(posedge cp2) begin
        if (ireset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Termination priority in BUS: err, then ack, then timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done_ok   = 1'b0;
        w_done_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (wb_rst) begin
                        w_state_nxt = ST_DONE;
                        w_done_err  = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUS;
                        w_start     = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (wb.wb_err_i) begin
                    w_state_nxt = ST_DONE;
                    w_done_err  = 1'b1;
                end else if (wb.wb_ack_i) begin
                    w_state_nxt = ST_DONE;
                    w_done_ok   = 1'b1;
                end else if ((P_TMO_EN != 0) && w_expired) begin
                    w_state_nxt = ST_DONE;
                    w_done_err  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cp2) begin
        if (ireset) begin
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_sel      <= '0;
            r_dat      <= '0;
            r_dbus_out <= '0;
            r_err_flag <= 1'b0;
        end else begin
            r_cyc <= (w_state_nxt == ST_BUS);
            if (w_start) begin
                r_adr <= {wb_adr_hi, ramadr};
                r_sel <= wb_be;
                r_we  <= ramwe;
                r_dat <= {4{dbus_in}};
            end
            if (w_done_err) begin
                r_dbus_out <= C_ERR_RDATA;
            end else if (w_done_ok && !r_we) begin
                r_dbus_out <= lane_sel(wb.wb_dat_i, r_adr[1:0]);
            end
            // A new error outranks a clear arriving on the same edge.
            if (w_done_err) begin
                r_err_flag <= 1'b1;
            end else if (err_clr) begin
                r_err_flag <= 1'b0;
            end
        end
    end

    assign cpuwait      = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUS);
    assign dbus_out     = r_dbus_out;
    assign err_flag     = r_err_flag;
    assign o_dbg_state  = r_state;

    assign wb.wb_cyc_o  = r_cyc;
    assign wb.wb_stb_o  = r_cyc;
    assign wb.wb_we_o   = r_we;
    assign wb.wb_adr_o  = r_adr;
    assign wb.wb_sel_o  = r_sel;
    assign wb.wb_dat_o  = r_dat;

endmodule
